// File: rtl/pad_input_conditioner.sv
// rtl/pad_input_conditioner.sv - per-pad synchronizer, debouncer and edge pulse generator
module pad_input_conditioner #(
  parameter int NUM_INPUT_PADS  = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_INPUT_PADS-1:0] pad_in,
  output logic [NUM_INPUT_PADS-1:0] input_clean,
  output logic [NUM_INPUT_PADS-1:0] rise_pulse,
  output logic [NUM_INPUT_PADS-1:0] fall_pulse,
  output logic                      any_change
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [NUM_INPUT_PADS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_INPUT_PADS-1:0] sync_d [SYNC_STAGES];
  logic [CW-1:0]             cnt_q  [NUM_INPUT_PADS];
  logic [CW-1:0]             cnt_d  [NUM_INPUT_PADS];
  logic [NUM_INPUT_PADS-1:0] clean_q, clean_d;
  logic [NUM_INPUT_PADS-1:0] rise_q, rise_d;
  logic [NUM_INPUT_PADS-1:0] fall_q, fall_d;
  logic                      any_q, any_d;
  logic [NUM_INPUT_PADS-1:0] sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Plain shift chain into the clk domain; nothing sits between stages.
  always_comb begin
    sync_d[0] = pad_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Per-bit debounce: accept the new level only after DEBOUNCE_CYCLES consecutive
  // mismatches; any match restarts the count. Pulses compare next vs current level.
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < NUM_INPUT_PADS; i++) begin
      cnt_d[i] = '0;
      if (sync_last[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          clean_d[i] = sync_last[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
    rise_d = clean_d & ~clean_q;
    fall_d = ~clean_d & clean_q;
    any_d  = |(rise_d | fall_d);
  end

  // State registers; reset clears everything including in-flight counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < NUM_INPUT_PADS; i++) begin
        cnt_q[i] <= '0;
      end
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int i = 0; i < NUM_INPUT_PADS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
    end
  end

  assign input_clean = clean_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign any_change  = any_q;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// tb/tb_pad_input_conditioner.sv - directed self-checking bench for pad_input_conditioner
module tb_pad_input_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] pad_in;
  logic [3:0] input_clean;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic       any_change;

  int errors = 0;
  int checks = 0;

  pad_input_conditioner #(
    .NUM_INPUT_PADS(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pad_in(pad_in),
    .input_clean(input_clean),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .any_change(any_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] c, input logic [3:0] r,
                           input logic [3:0] f, input logic a);
    check({tag, ".clean"}, input_clean, c);
    check({tag, ".rise"}, rise_pulse, r);
    check({tag, ".fall"}, fall_pulse, f);
    check({tag, ".any"}, {3'b0, any_change}, {3'b0, a});
  endtask

  task automatic reset_low_pads();
    rst_n  = 1'b0;
    pad_in = 4'h0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_n  = 1'b0;
    pad_in = 4'hF;
    #1;

    // Reset with pads high
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check_all("rst_hold", 4'h0, 4'h0, 4'h0, 1'b0);
    end
    rst_n = 1'b1;
    tick(5);
    check_all("rst_rel_e5", 4'h0, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_all("rst_rel_e6", 4'hF, 4'hF, 4'h0, 1'b1);
    tick(1);
    check_all("rst_rel_e7", 4'hF, 4'h0, 4'h0, 1'b0);

    // Glitch rejection: bit0 high for 3 cycles
    reset_low_pads();
    pad_in = 4'h1;
    tick(3);
    pad_in = 4'h0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check_all("glitch", 4'h0, 4'h0, 4'h0, 1'b0);
    end

    // Clean step on bit2, rise then fall
    pad_in = 4'h4;
    tick(5);
    check_all("step_up_e5", 4'h0, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_all("step_up_e6", 4'h4, 4'h4, 4'h0, 1'b1);
    tick(1);
    check_all("step_up_e7", 4'h4, 4'h0, 4'h0, 1'b0);
    tick(3);
    pad_in = 4'h0;
    tick(5);
    check_all("step_dn_e5", 4'h4, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_all("step_dn_e6", 4'h0, 4'h0, 4'h4, 1'b1);
    tick(1);
    check_all("step_dn_e7", 4'h0, 4'h0, 4'h0, 1'b0);

    // Bounce then settle on bit1
    for (int k = 0; k < 10; k++) begin
      pad_in = (k % 2 == 0) ? 4'h2 : 4'h0;
      tick(1);
      check_all("bounce", 4'h0, 4'h0, 4'h0, 1'b0);
    end
    pad_in = 4'h2;
    tick(5);
    check_all("settle_e5", 4'h0, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_all("settle_e6", 4'h2, 4'h2, 4'h0, 1'b1);
    tick(1);
    check_all("settle_e7", 4'h2, 4'h0, 4'h0, 1'b0);

    // Simultaneous opposite edges from input_clean=8
    reset_low_pads();
    pad_in = 4'h8;
    tick(6);
    check_all("pre_simul", 4'h8, 4'h8, 4'h0, 1'b1);
    tick(2);
    pad_in = 4'h1;
    tick(5);
    check_all("simul_e5", 4'h8, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_all("simul_e6", 4'h1, 4'h1, 4'h8, 1'b1);
    tick(1);
    check_all("simul_e7", 4'h1, 4'h0, 4'h0, 1'b0);

    // Reset mid-count on bit3
    reset_low_pads();
    check_all("mid_pre", 4'h0, 4'h0, 4'h0, 1'b0);
    pad_in = 4'h8;
    tick(5);
    check_all("mid_e5", 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b0;
    tick(1);
    check_all("mid_rst", 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    tick(1);
    check_all("mid_rel_e1", 4'h0, 4'h0, 4'h0, 1'b0);
    tick(4);
    check_all("mid_rel_e5", 4'h0, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_all("mid_rel_e6", 4'h8, 4'h8, 4'h0, 1'b1);
    tick(1);
    check_all("mid_rel_e7", 4'h8, 4'h0, 4'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
